// File: rtl/semaphore_pkg.sv
// Shared constants and helpers for the semaphore address fabric.
// Slot count derivation and per-slot address match.
package semaphore_pkg;

    localparam int SLOT_W = 4;
    localparam int ADDR_W = 8;

    function automatic int slot_count(input int n_sem, input int n_core);
        return n_sem * n_core;
    endfunction

    function automatic logic slot_hit(
        input logic [ADDR_W-1:0] addr,
        input int                idx
    );
        return addr == ADDR_W'(idx);
    endfunction

endpackage

// File: rtl/semaphore_slot_decoder.sv
// Address to one-hot slot select; out-of-range addresses select nothing.
// Shared by the write demux and the read mux.
module semaphore_slot_decoder
    import semaphore_pkg::*;
#(
    parameter int SLOTS = 8
) (
    input  logic [ADDR_W-1:0] addr_i,
    output logic [SLOTS-1:0]  onehot_o,
    output logic              valid_o
);

    for (genvar i = 0; i < SLOTS; i++) begin : g_hit
        assign onehot_o[i] = slot_hit(addr_i, i);
    end

    // Only indices below SLOTS can match, so any hit means in range.
    assign valid_o = |onehot_o;

endmodule

// File: rtl/semaphore_addr_fabric.sv
// Registered write demux and combinational read mux between the
// semaphore controller and the bank of per-slot semaphore counters.
module semaphore_addr_fabric
    import semaphore_pkg::*;
#(
    parameter int NumberOfSemaphores = 4,
    parameter int NumberOfCores      = 2,
    localparam int SLOTS = slot_count(NumberOfSemaphores, NumberOfCores)
) (
    input  logic                    CLK,
    input  logic                    RESET_N,
    input  logic [ADDR_W-1:0]       SEMAPHOREFABRIC_Addr_fromCPU,
    input  logic                    SEMAPHOREFABRIC_EN_fromCPU,
    input  logic                    SEMAPHOREFABRIC_WR_fromCPU,
    input  logic [SLOT_W-1:0]       SEMAPHOREFABRIC_Data_fromCPU,
    output logic [SLOTS-1:0]        SEMAPHOREFABRIC_EN_toSemaphore,
    output logic [SLOTS-1:0]        SEMAPHOREFABRIC_WR_toSemaphore,
    output logic [SLOT_W*SLOTS-1:0] SEMAPHOREFABRIC_Data_toSemaphore,
    input  logic [SLOTS-1:0]        SEMAPHOREFABRIC_Blocking_fromSemaphore,
    output logic                    SEMAPHOREFABRIC_Blocking_toCPU,
    input  logic [SLOT_W*SLOTS-1:0] SEMAPHOREFABRIC_Data_fromSemaphore,
    output logic [SLOT_W-1:0]       SEMAPHOREFABRIC_Data_toCPU
);

    logic [SLOTS-1:0]        sel;
    logic                    sel_valid;
    logic [SLOTS-1:0]        en_d, en_q;
    logic [SLOTS-1:0]        wr_d, wr_q;
    logic [SLOT_W*SLOTS-1:0] data_d, data_q;

    semaphore_slot_decoder #(
        .SLOTS(SLOTS)
    ) u_dec (
        .addr_i  (SEMAPHOREFABRIC_Addr_fromCPU),
        .onehot_o(sel),
        .valid_o (sel_valid)
    );

    always_comb begin
        en_d   = '0;
        wr_d   = '0;
        data_d = '0;
        if (SEMAPHOREFABRIC_EN_fromCPU) begin
            en_d = sel;
            if (SEMAPHOREFABRIC_WR_fromCPU) begin
                wr_d = sel;
            end
        end
        for (int i = 0; i < SLOTS; i++) begin
            if (en_d[i]) begin
                data_d[SLOT_W*i +: SLOT_W] = SEMAPHOREFABRIC_Data_fromCPU;
            end
        end
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            en_q   <= '0;
            wr_q   <= '0;
            data_q <= '0;
        end else begin
            en_q   <= en_d;
            wr_q   <= wr_d;
            data_q <= data_d;
        end
    end

    assign SEMAPHOREFABRIC_EN_toSemaphore   = en_q;
    assign SEMAPHOREFABRIC_WR_toSemaphore   = wr_q;
    assign SEMAPHOREFABRIC_Data_toSemaphore = data_q;

    // AND-OR mux keeps unselected slots from leaking X onto the read bus.
    always_comb begin
        SEMAPHOREFABRIC_Data_toCPU = '0;
        for (int i = 0; i < SLOTS; i++) begin
            SEMAPHOREFABRIC_Data_toCPU |=
                SEMAPHOREFABRIC_Data_fromSemaphore[SLOT_W*i +: SLOT_W]
                & {SLOT_W{sel[i]}};
        end
    end

    assign SEMAPHOREFABRIC_Blocking_toCPU =
        !sel_valid || |(sel & SEMAPHOREFABRIC_Blocking_fromSemaphore);

endmodule

// File: tb/tb_semaphore_addr_fabric.sv
// Directed bench for semaphore_addr_fabric with a per-cycle model check.
// Default parameters: 8 slots.
module tb_semaphore_addr_fabric;

    logic        clk;
    logic        rst_n;
    logic [7:0]  addr;
    logic        en;
    logic        wr;
    logic [3:0]  din;
    logic [7:0]  en_out;
    logic [7:0]  wr_out;
    logic [31:0] data_out;
    logic [7:0]  blk_from;
    logic        blk_cpu;
    logic [31:0] data_from;
    logic [3:0]  data_cpu;

    int checks;
    int failures;

    logic [7:0]  m_en;
    logic [7:0]  m_wr;
    logic [31:0] m_data;

    semaphore_addr_fabric dut (
        .CLK                                   (clk),
        .RESET_N                               (rst_n),
        .SEMAPHOREFABRIC_Addr_fromCPU          (addr),
        .SEMAPHOREFABRIC_EN_fromCPU            (en),
        .SEMAPHOREFABRIC_WR_fromCPU            (wr),
        .SEMAPHOREFABRIC_Data_fromCPU          (din),
        .SEMAPHOREFABRIC_EN_toSemaphore        (en_out),
        .SEMAPHOREFABRIC_WR_toSemaphore        (wr_out),
        .SEMAPHOREFABRIC_Data_toSemaphore      (data_out),
        .SEMAPHOREFABRIC_Blocking_fromSemaphore(blk_from),
        .SEMAPHOREFABRIC_Blocking_toCPU        (blk_cpu),
        .SEMAPHOREFABRIC_Data_fromSemaphore    (data_from),
        .SEMAPHOREFABRIC_Data_toCPU            (data_cpu)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // Write-side model: the selected slot is just 1 << addr when in range.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_en   = '0;
            m_wr   = '0;
            m_data = '0;
        end else if (en && addr < 8) begin
            m_en   = 8'd1 << addr;
            m_wr   = wr ? (8'd1 << addr) : 8'd0;
            m_data = {28'd0, din} << (4 * addr);
        end else begin
            m_en   = '0;
            m_wr   = '0;
            m_data = '0;
        end
    end

    always @(negedge clk) begin
        int ai;
        logic       e_blk;
        logic [3:0] e_dat;
        ai = int'(addr);
        e_blk = 1'b1;
        e_dat = 4'h0;
        if (ai < 8) begin
            e_blk = blk_from[ai];
            e_dat = data_from[4*ai +: 4];
        end
        chk("model_en", {24'd0, en_out}, {24'd0, m_en});
        chk("model_wr", {24'd0, wr_out}, {24'd0, m_wr});
        chk("model_data", data_out, m_data);
        chk("model_blk", {31'd0, blk_cpu}, {31'd0, e_blk});
        chk("model_rdata", {28'd0, data_cpu}, {28'd0, e_dat});
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [7:0] a, input logic e,
                         input logic w, input logic [3:0] d);
        addr = a;
        en   = e;
        wr   = w;
        din  = d;
    endtask

    initial begin
        checks    = 0;
        failures  = 0;
        rst_n     = 1'b0;
        blk_from  = '0;
        data_from = '0;
        drive(8'd0, 1'b0, 1'b0, 4'h0);
        #3;
        chk("reset_en", {24'd0, en_out}, 32'h0);
        chk("reset_data", data_out, 32'h0);
        step();
        step();
        rst_n = 1'b1;

        // single write to slot 5
        drive(8'd5, 1'b1, 1'b1, 4'hA);
        step();
        chk("t1_en", {24'd0, en_out}, 32'h20);
        chk("t1_wr", {24'd0, wr_out}, 32'h20);
        chk("t1_data", data_out, 32'h00A0_0000);
        drive(8'd5, 1'b0, 1'b0, 4'h0);
        step();
        chk("t1_idle_en", {24'd0, en_out}, 32'h0);
        chk("t1_idle_data", data_out, 32'h0);

        // enable without write strobe
        drive(8'd0, 1'b1, 1'b0, 4'h3);
        step();
        chk("t2_en", {24'd0, en_out}, 32'h01);
        chk("t2_wr", {24'd0, wr_out}, 32'h0);
        chk("t2_data", data_out, 32'h3);

        // read mux
        drive(8'd3, 1'b0, 1'b0, 4'h0);
        data_from = 32'hF000_7000;
        #1;
        chk("t3_rd3", {28'd0, data_cpu}, 32'h7);
        addr = 8'd7;
        #1;
        chk("t3_rd7", {28'd0, data_cpu}, 32'hF);

        // blocking mux
        blk_from = 8'b0000_0100;
        addr = 8'd2;
        #1;
        chk("t4_blk2", {31'd0, blk_cpu}, 32'h1);
        addr = 8'd1;
        #1;
        chk("t4_blk1", {31'd0, blk_cpu}, 32'h0);

        // out of range
        drive(8'd8, 1'b1, 1'b1, 4'h9);
        #1;
        chk("t5_blk", {31'd0, blk_cpu}, 32'h1);
        chk("t5_rdata", {28'd0, data_cpu}, 32'h0);
        step();
        chk("t5_en", {24'd0, en_out}, 32'h0);
        chk("t5_wr", {24'd0, wr_out}, 32'h0);

        // sweep addresses, held requests, model-checked
        for (int i = 0; i < 10; i++) begin
            drive(8'(i), 1'b1, i[0], 4'(i + 3));
            step();
        end
        drive(8'd255, 1'b1, 1'b1, 4'hF);
        step();
        chk("t5_255_en", {24'd0, en_out}, 32'h0);

        // async reset mid-write
        drive(8'd6, 1'b1, 1'b1, 4'h5);
        step();
        chk("t6_inflight_en", {24'd0, en_out}, 32'h40);
        chk("t6_inflight_data", data_out, 32'h0500_0000);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6_rst_en", {24'd0, en_out}, 32'h0);
        chk("t6_rst_wr", {24'd0, wr_out}, 32'h0);
        chk("t6_rst_data", data_out, 32'h0);
        step();
        rst_n = 1'b1;
        #1;
        chk("t6_rel_en", {24'd0, en_out}, 32'h0);
        step();
        chk("t6_back_en", {24'd0, en_out}, 32'h40);
        chk("t6_back_wr", {24'd0, wr_out}, 32'h40);

        drive(8'd0, 1'b0, 1'b0, 4'h0);
        step();
        step();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/semaphore_addr_fabric.md
Name: semaphore_addr_fabric

Overview:
Address-decoding fabric between the semaphore router controller and the bank of NumberOfSemaphores*NumberOfCores semaphore counter slots. The write side demultiplexes enable, write strobe and 4-bit count data to the addressed slot through one register stage. The read side combinationally multiplexes the addressed slot's blocking flag and 4-bit count back to the controller. It merges the enable-router, blocking-mux and data-decoder functions into one clocked block.

Parameters:
NumberOfSemaphores, 4, semaphores per core.
NumberOfCores, 2, number of cores.
Derived constant SLOTS = NumberOfSemaphores*NumberOfCores; the block requires 1 <= SLOTS <= 256.

Ports:
CLK  in  1  system clock, rising edge.
RESET_N  in  1  asynchronous, active-low reset.
SEMAPHOREFABRIC_Addr_fromCPU  in  8  slot index (unsigned); shared by the read and write paths.
SEMAPHOREFABRIC_EN_fromCPU  in  1  write-side enable request.
SEMAPHOREFABRIC_WR_fromCPU  in  1  write strobe request.
SEMAPHOREFABRIC_Data_fromCPU  in  4  count value to write.
SEMAPHOREFABRIC_EN_toSemaphore  out  SLOTS  one-hot per-slot enable.
SEMAPHOREFABRIC_WR_toSemaphore  out  SLOTS  one-hot per-slot write strobe.
SEMAPHOREFABRIC_Data_toSemaphore  out  4*SLOTS  per-slot count input; slot i is bits [4i+3:4i].
SEMAPHOREFABRIC_Blocking_fromSemaphore  in  SLOTS  per-slot busy flag.
SEMAPHOREFABRIC_Blocking_toCPU  out  1  busy flag of the addressed slot.
SEMAPHOREFABRIC_Data_fromSemaphore  in  4*SLOTS  per-slot count outputs; slot i is bits [4i+3:4i].
SEMAPHOREFABRIC_Data_toCPU  out  4  count of the addressed slot.

Behaviour:
- Slot mapping: a = Addr_fromCPU. The address is valid iff a < SLOTS. Slot a uses bit [a] of the 1-bit vectors and bits [4a+3:4a] of the 4-bit vectors.
- Write path, registered with 1-cycle latency. On each CLK rising edge:
  - EN_toSemaphore[i] <= EN_fromCPU && valid && (a == i).
  - WR_toSemaphore[i] <= EN_fromCPU && WR_fromCPU && valid && (a == i). WR is never asserted without EN on the same slot.
  - Data_toSemaphore slot i <= Data_fromCPU when EN_fromCPU && valid && (a == i); otherwise 4'h0. Non-selected slots always carry 0; no high-Z values are used.
- At most one slot's EN/WR bit is high in any cycle.
- A write request held for N cycles yields N consecutive cycles of EN/WR on the target slot, delayed by one cycle. No pulse-stretching and no edge detection.
- Changing the address between cycles moves the selection at the next edge, with no overlap.
- Read path, combinational with zero latency:
  - Blocking_toCPU = Blocking_fromSemaphore[a] when valid, else 1. Invalid addresses report busy so the controller never acts on them.
  - Data_toCPU = slot a of Data_fromSemaphore when valid, else 4'h0.
- Reset: RESET_N low immediately clears all EN_toSemaphore, WR_toSemaphore and Data_toSemaphore bits to 0, including mid-write; it does not wait for a clock edge. Read-path outputs do not depend on reset. The first edge after reset release samples the inputs normally.
- No internal state besides the write-side output registers. No X or Z is propagated from unselected inputs.

Decomposition:
- Shared package semaphore_pkg: SLOT_W=4 (count width), ADDR_W=8, the localparam function slot_count(NumberOfSemaphores, NumberOfCores), and the one-hot decode helper.
- One natural sub-module: semaphore_slot_decoder. It is a combinational address-to-one-hot decoder with a valid output, shared by the write and read paths.

Test Plan:
Default parameters throughout, SLOTS=8.
1. Write: Addr=5, EN=1, WR=1, Data=4'hA for one cycle -> next cycle EN_toSemaphore=8'b0010_0000, WR_toSemaphore=8'b0010_0000, Data_toSemaphore[23:20]=4'hA, all other bits 0. The cycle after (EN=0), all write outputs are 0.
2. Enable only: Addr=0, EN=1, WR=0, Data=4'h3 -> next cycle EN_toSemaphore=8'b0000_0001, WR_toSemaphore=0, Data_toSemaphore[3:0]=4'h3.
3. Read mux: Data_fromSemaphore slot 3 = 4'h7 and slot 7 = 4'hF; Addr=3 -> Data_toCPU=4'h7 the same cycle; Addr=7 -> 4'hF.
4. Blocking mux: Blocking_fromSemaphore=8'b0000_0100; Addr=2 -> Blocking_toCPU=1; Addr=1 -> 0.
5. Out of range: Addr=8 with EN=WR=1 -> no EN/WR bit set next cycle; Blocking_toCPU=1; Data_toCPU=4'h0.
6. Async reset: write in flight to Addr=6; drop RESET_N between clock edges -> EN, WR and Data outputs go to 0 before the next edge. Release reset with EN=1 held -> the outputs reassert one edge later.
